// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake, CR16-style flags and iterative multiplier
module alu_pipe #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       opcode,
   input  logic [WIDTH-1:0] r1,
   input  logic [WIDTH-1:0] r2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rout,
   output logic [4:0]       flags,
   output logic             illegal
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_NOT  = 8'h04;
   localparam logic [7:0] OP_ADD  = 8'h05;
   localparam logic [7:0] OP_ADDU = 8'h06;
   localparam logic [7:0] OP_ADDC = 8'h07;
   localparam logic [7:0] OP_RSH  = 8'h08;
   localparam logic [7:0] OP_SUB  = 8'h09;
   localparam logic [7:0] OP_SUBC = 8'h0A;
   localparam logic [7:0] OP_CMP  = 8'h0B;
   localparam logic [7:0] OP_ALSH = 8'h0C;
   localparam logic [7:0] OP_MULT = 8'h0E;
   localparam logic [7:0] OP_ARSH = 8'h0F;
   localparam logic [7:0] OP_LSH  = 8'h84;

   // bit positions inside flags = {C,L,F,Z,N}
   localparam int FC = 4;
   localparam int FL = 3;
   localparam int FF = 2;
   localparam int FZ = 1;
   localparam int FN = 0;

   localparam logic [WIDTH-1:0] W_LIM    = WIDTH'(WIDTH);
   localparam logic [SW-1:0]    CNT_LAST = SW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

   typedef enum logic {IDLE, MUL} state_t;
   state_t state;

   // multiplier working registers
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [SW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   prod_lo;
   logic [WIDTH-1:0]   prod_hi;

   // single-cycle datapath
   logic                    cin;
   logic [WIDTH:0]          sum;
   logic [WIDTH:0]          diff;
   logic                    add_ovf;
   logic                    sub_ovf;
   logic                    msb;
   logic                    sh_big;
   logic [SW-1:0]           sh;
   logic [SW:0]             sh_p1;
   logic [WIDTH-1:0]        alsh_mask;
   logic                    alsh_f;
   logic [WIDTH-1:0]        lsh_val;
   logic [WIDTH-1:0]        rsh_val;
   logic [WIDTH-1:0]        arsh_val;
   logic signed [WIDTH-1:0] r1_s;

   logic [WIDTH-1:0] res;
   logic [4:0]       nflags;
   logic             bad;
   logic             is_mul;
   logic             upd_zn;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);

   // carry-in is the flag value held before the accepting edge
   assign cin     = (opcode == OP_ADDC || opcode == OP_SUBC) ? flags[FC] : 1'b0;
   assign sum     = {1'b0, r1} + {1'b0, r2} + (WIDTH+1)'(cin);
   assign diff    = {1'b0, r1} - {1'b0, r2} - (WIDTH+1)'(cin);
   assign msb     = r1[WIDTH-1];
   assign add_ovf = (r1[WIDTH-1] == r2[WIDTH-1]) && (sum[WIDTH-1] != msb);
   assign sub_ovf = (r1[WIDTH-1] != r2[WIDTH-1]) && (diff[WIDTH-1] != msb);

   // shift amount saturates: anything >= WIDTH shifts everything out
   assign sh_big   = (r2 >= W_LIM);
   assign sh       = r2[SW-1:0];
   assign sh_p1    = {1'b0, sh} + (SW+1)'(1);
   assign r1_s     = r1;
   assign lsh_val  = sh_big ? '0 : (r1 << sh);
   assign rsh_val  = sh_big ? '0 : (r1 >> sh);
   assign arsh_val = sh_big ? {WIDTH{msb}} : (r1_s >>> sh);

   // ALSH overflow: the top SH+1 bits (shifted-out bits plus new MSB) must all match the old MSB
   assign alsh_mask = ~(ONES >> sh_p1);
   assign alsh_f    = sh_big ? (|r1) : (|((r1 ^ {WIDTH{msb}}) & alsh_mask));

   // one shift-add step of the multiplier
   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign prod_lo  = acc_next[WIDTH-1:0];
   assign prod_hi  = acc_next[2*WIDTH-1:WIDTH];

   // decode opcode into result, next flag value and illegal/multiply indications
   always_comb begin
      res    = '0;
      nflags = flags;
      bad    = 1'b0;
      is_mul = 1'b0;
      upd_zn = 1'b1;
      case (opcode)
         OP_AND:  res = r1 & r2;
         OP_OR:   res = r1 | r2;
         OP_XOR:  res = r1 ^ r2;
         OP_NOT:  res = ~r1;
         OP_ADD, OP_ADDC: begin
            res        = sum[WIDTH-1:0];
            nflags[FC] = sum[WIDTH];
            nflags[FF] = add_ovf;
         end
         OP_ADDU: begin
            res        = sum[WIDTH-1:0];
            nflags[FC] = sum[WIDTH];
         end
         OP_SUB, OP_SUBC: begin
            res        = diff[WIDTH-1:0];
            nflags[FC] = diff[WIDTH];
            nflags[FF] = sub_ovf;
         end
         OP_CMP: begin
            upd_zn     = 1'b0;
            nflags[FZ] = (r1 == r2);
            nflags[FN] = ($signed(r1) < $signed(r2));
            nflags[FL] = (r1 < r2);
         end
         OP_LSH:  res = lsh_val;
         OP_RSH:  res = rsh_val;
         OP_ALSH: begin
            res        = lsh_val;
            nflags[FF] = alsh_f;
         end
         OP_ARSH: res = arsh_val;
         OP_MULT: begin
            if (MUL_EN) begin
               is_mul = 1'b1;
            end else begin
               bad    = 1'b1;
               upd_zn = 1'b0;
            end
         end
         default: begin
            bad    = 1'b1;
            upd_zn = 1'b0;
         end
      endcase
      if (upd_zn) begin
         nflags[FZ] = (res == '0);
         nflags[FN] = res[WIDTH-1];
      end
   end

   // control FSM with registered result, flags and output handshake
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rout      <= '0;
         flags     <= '0;
         out_valid <= 1'b0;
         illegal   <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
      end else begin
         if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  if (is_mul) begin
                     state  <= MUL;
                     acc    <= '0;
                     mcand  <= {{WIDTH{1'b0}}, r1};
                     mplier <= r2;
                     cnt    <= '0;
                  end else begin
                     rout      <= res;
                     flags     <= nflags;
                     illegal   <= bad;
                     out_valid <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + SW'(1);
               if (cnt == CNT_LAST) begin
                  state     <= IDLE;
                  rout      <= prod_lo;
                  flags[FF] <= |prod_hi;
                  flags[FZ] <= (prod_lo == '0);
                  flags[FN] <= prod_lo[WIDTH-1];
                  illegal   <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
